// File: rtl/keypad_pin_ctrl.sv
// Keypad access controller: press/release qualified keystrokes, PIN entry and check,
// unlock/error/lockout status. Define PIN_CHANGE_EN to enable the in-OPEN PIN change mode.
module keypad_pin_ctrl #(
  parameter int                     PIN_LEN        = 4,
  parameter logic [4*PIN_LEN-1:0]   PIN_DEFAULT    = 16'h1234,
  parameter int                     RELEASE_CYCLES = 1000000,
  parameter int                     OPEN_CYCLES    = 150000000,
  parameter int                     MAX_FAILS      = 3,
  parameter int                     LOCK_CYCLES    = 500000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_valid,
  input  logic [3:0]           key_code,
  output logic                 key_ack,
  output logic [4*PIN_LEN-1:0] entry_digits,
  output logic [3:0]           digit_count,
  output logic                 unlocked,
  output logic                 err,
  output logic                 locked_out
);

  localparam int EW   = 4 * PIN_LEN;
  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int RW   = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam int FW   = $clog2(MAX_FAILS + 1);

  localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_CYCLES - 1);
  localparam logic [RW-1:0] REL_LAST   = RW'(RELEASE_CYCLES - 1);
  localparam logic [FW-1:0] FAIL_LIMIT = FW'(MAX_FAILS);
  localparam logic [3:0]    LEN        = 4'(PIN_LEN);
  localparam logic [3:0]    K_STAR     = 4'd14;
  localparam logic [3:0]    K_HASH     = 4'd15;
`ifdef PIN_CHANGE_EN
  localparam logic [3:0]    K_A        = 4'd10;
  localparam logic [3:0]    K_B        = 4'd11;
`endif

  typedef enum logic [2:0] {
    S_ENTRY   = 3'd0,
    S_CHECK   = 3'd1,
    S_OPEN    = 3'd2,
`ifdef PIN_CHANGE_EN
    S_SET     = 3'd4,
`endif
    S_LOCKOUT = 3'd3
  } state_t;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic [RW-1:0]   rel_cnt_q, rel_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [FW-1:0]   fails_q, fails_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [3:0]      count_q, count_d;
  logic            key_ack_q, key_ack_d;
  logic            err_q, err_d;
  logic            unlocked_q, unlocked_d;
  logic            locked_out_q, locked_out_d;
  logic [EW-1:0]   pin;
  logic            accept;
  logic            is_digit;
  logic            editing;
  logic            full;

`ifdef PIN_CHANGE_EN
  logic [EW-1:0]   pin_q, pin_d;
  assign pin = pin_q;
`else
  assign pin = PIN_DEFAULT;
`endif

  assign accept   = key_valid && armed_q;
  assign is_digit = (key_code <= 4'd9);
  assign full     = (count_q >= LEN);

  // Next-state logic for the key qualifier, entry buffer, timers and status FSM.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q;
    rel_cnt_d = rel_cnt_q;
    timer_d   = timer_q;
    fails_d   = fails_q;
    entry_d   = entry_q;
    count_d   = count_q;
    key_ack_d = accept;
    err_d     = 1'b0;
`ifdef PIN_CHANGE_EN
    pin_d     = pin_q;
`endif

    if (key_valid) begin
      rel_cnt_d = '0;
      if (accept) begin
        armed_d = 1'b0;
      end else begin
        armed_d = armed_q;
      end
    end else if (!armed_q) begin
      if (rel_cnt_q == REL_LAST) begin
        armed_d   = 1'b1;
        rel_cnt_d = '0;
      end else begin
        rel_cnt_d = rel_cnt_q + RW'(1);
      end
    end else begin
      rel_cnt_d = '0;
    end

    // Digit and '*' handling is shared by ENTRY and SET.
`ifdef PIN_CHANGE_EN
    editing = accept && ((state_q == S_ENTRY) || (state_q == S_SET));
`else
    editing = accept && (state_q == S_ENTRY);
`endif
    if (editing && is_digit && !full) begin
      entry_d      = entry_q << 4;
      entry_d[3:0] = key_code;
      count_d      = count_q + 4'd1;
    end else if (editing && (key_code == K_STAR)) begin
      entry_d = '0;
      count_d = 4'd0;
    end else begin
      entry_d = entry_d;
    end

    case (state_q)
      S_ENTRY: begin
        if (accept && (key_code == K_HASH)) begin
          if (full) begin
            state_d = S_CHECK;
          end else begin
            err_d   = 1'b1;
            entry_d = '0;
            count_d = 4'd0;
          end
        end else begin
          state_d = S_ENTRY;
        end
      end
      S_CHECK: begin
        if (entry_q == pin) begin
          state_d = S_OPEN;
          fails_d = '0;
        end else begin
          err_d   = 1'b1;
          fails_d = fails_q + FW'(1);
          entry_d = '0;
          count_d = 4'd0;
          if ((fails_q + FW'(1)) == FAIL_LIMIT) begin
            state_d = S_LOCKOUT;
          end else begin
            state_d = S_ENTRY;
          end
        end
      end
      S_OPEN: begin
        if (timer_q == OPEN_LAST || (accept && key_code == K_STAR)) begin
          state_d = S_ENTRY;
          entry_d = '0;
          count_d = 4'd0;
`ifdef PIN_CHANGE_EN
        end else if (accept && key_code == K_A) begin
          state_d = S_SET;
          entry_d = '0;
          count_d = 4'd0;
`endif
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef PIN_CHANGE_EN
      S_SET: begin
        if (accept && key_code == K_HASH) begin
          if (full) begin
            pin_d   = entry_q;
            state_d = S_ENTRY;
          end else begin
            err_d   = 1'b1;
          end
          entry_d = '0;
          count_d = 4'd0;
        end else if (accept && key_code == K_B) begin
          state_d = S_ENTRY;
          entry_d = '0;
          count_d = 4'd0;
        end else begin
          state_d = S_SET;
        end
      end
`endif
      S_LOCKOUT: begin
        if (timer_q == LOCK_LAST) begin
          state_d = S_ENTRY;
          fails_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_ENTRY;
        entry_d = '0;
        count_d = 4'd0;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end else begin
      timer_d = timer_d;
    end

`ifdef PIN_CHANGE_EN
    unlocked_d = (state_d == S_OPEN) || (state_d == S_SET);
`else
    unlocked_d = (state_d == S_OPEN);
`endif
    locked_out_d = (state_d == S_LOCKOUT);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_ENTRY;
      armed_q      <= 1'b1;
      rel_cnt_q    <= '0;
      timer_q      <= '0;
      fails_q      <= '0;
      entry_q      <= '0;
      count_q      <= 4'd0;
      key_ack_q    <= 1'b0;
      err_q        <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
`ifdef PIN_CHANGE_EN
      pin_q        <= PIN_DEFAULT;
`endif
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      rel_cnt_q    <= rel_cnt_d;
      timer_q      <= timer_d;
      fails_q      <= fails_d;
      entry_q      <= entry_d;
      count_q      <= count_d;
      key_ack_q    <= key_ack_d;
      err_q        <= err_d;
      unlocked_q   <= unlocked_d;
      locked_out_q <= locked_out_d;
`ifdef PIN_CHANGE_EN
      pin_q        <= pin_d;
`endif
    end
  end

  assign key_ack      = key_ack_q;
  assign entry_digits = entry_q;
  assign digit_count  = count_q;
  assign unlocked     = unlocked_q;
  assign err          = err_q;
  assign locked_out   = locked_out_q;

endmodule

// File: tb/tb_keypad_pin_ctrl.sv
// Directed bench for keypad_pin_ctrl with short timing parameters.
module tb_keypad_pin_ctrl;

  logic        clk;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack;
  logic [15:0] entry_digits;
  logic [3:0]  digit_count;
  logic        unlocked;
  logic        err;
  logic        locked_out;

  int tests;
  int fails;
  int ack_cnt, err_cnt, unl_cnt, lk_cnt;
  int a0, e0, u0, l0;

  keypad_pin_ctrl #(
    .PIN_LEN(4), .PIN_DEFAULT(16'h1234), .RELEASE_CYCLES(4),
    .OPEN_CYCLES(20), .MAX_FAILS(3), .LOCK_CYCLES(30)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ack(key_ack), .entry_digits(entry_digits), .digit_count(digit_count),
    .unlocked(unlocked), .err(err), .locked_out(locked_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and level counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (key_ack) ack_cnt <= ack_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
    if (unlocked) unl_cnt <= unl_cnt + 1;
    if (locked_out) lk_cnt <= lk_cnt + 1;
  end

  task automatic press(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic type_code(input logic [15:0] code);
    press(code[15:12]);
    press(code[11:8]);
    press(code[7:4]);
    press(code[3:0]);
    press(4'd15);
  endtask

  task automatic test_reset;
    rst = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if ({key_ack, err, unlocked, locked_out} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {key_ack, err, unlocked, locked_out}); end
    tests++; if (entry_digits !== 16'h0000) begin fails++; $display("FAIL reset_entry: got %h expected 0000", entry_digits); end
    tests++; if (digit_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", digit_count); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_hold;
    a0 = ack_cnt;
    key_code = 4'd5; key_valid = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    key_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++; if (ack_cnt - a0 !== 1) begin fails++; $display("FAIL hold_ack: got %0d expected 1", ack_cnt - a0); end
    tests++; if (digit_count !== 4'd1) begin fails++; $display("FAIL hold_count: got %0d expected 1", digit_count); end
    tests++; if (entry_digits !== 16'h0005) begin fails++; $display("FAIL hold_entry: got %h expected 0005", entry_digits); end
    press(4'd14);
    tests++; if (digit_count !== 4'd0) begin fails++; $display("FAIL star_clear: got %0d expected 0", digit_count); end
  endtask

  task automatic test_unlock;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    tests++; if (entry_digits !== 16'h1234 || digit_count !== 4'd4) begin fails++; $display("FAIL entry_1234: got %h/%0d expected 1234/4", entry_digits, digit_count); end
    u0 = unl_cnt; e0 = err_cnt;
    press(4'd15);
    tests++; if (unlocked !== 1'b1) begin fails++; $display("FAIL unlock: got %b expected 1", unlocked); end
    repeat (30) @(posedge clk);
    #1;
    tests++; if (unl_cnt - u0 !== 20) begin fails++; $display("FAIL open_cycles: got %0d expected 20", unl_cnt - u0); end
    tests++; if (unlocked !== 1'b0 || digit_count !== 4'd0 || err_cnt != e0) begin fails++; $display("FAIL open_exit: got %b/%0d/%0d expected 0/0/0", unlocked, digit_count, err_cnt - e0); end
  endtask

  task automatic test_short;
    e0 = err_cnt;
    press(4'd1); press(4'd2); press(4'd15);
    tests++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL short_err: got %0d expected 1", err_cnt - e0); end
    tests++; if (digit_count !== 4'd0 || entry_digits !== 16'h0000) begin fails++; $display("FAIL short_clear: got %0d/%h expected 0/0000", digit_count, entry_digits); end
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
    tests++; if (digit_count !== 4'd4 || entry_digits !== 16'h1234) begin fails++; $display("FAIL full_discard: got %0d/%h expected 4/1234", digit_count, entry_digits); end
    press(4'd14);
  endtask

  task automatic test_lockout;
    e0 = err_cnt;
    type_code(16'h9999);
    type_code(16'h9999);
    tests++; if (locked_out !== 1'b0) begin fails++; $display("FAIL early_lock: got %b expected 0", locked_out); end
    l0 = lk_cnt;
    type_code(16'h9999);
    tests++; if (err_cnt - e0 !== 3) begin fails++; $display("FAIL wrong_err: got %0d expected 3", err_cnt - e0); end
    tests++; if (locked_out !== 1'b1) begin fails++; $display("FAIL lockout: got %b expected 1", locked_out); end
    a0 = ack_cnt;
    type_code(16'h1234);
    tests++; if (ack_cnt - a0 !== 5) begin fails++; $display("FAIL lock_ack: got %0d expected 5", ack_cnt - a0); end
    tests++; if (unlocked !== 1'b0 || digit_count !== 4'd0) begin fails++; $display("FAIL lock_discard: got %b/%0d expected 0/0", unlocked, digit_count); end
    repeat (5) @(posedge clk);
    #1;
    tests++; if (lk_cnt - l0 !== 30 || locked_out !== 1'b0) begin fails++; $display("FAIL lock_cycles: got %0d/%b expected 30/0", lk_cnt - l0, locked_out); end
    type_code(16'h1234);
    tests++; if (unlocked !== 1'b1) begin fails++; $display("FAIL post_lock_unlock: got %b expected 1", unlocked); end
  endtask

  task automatic test_star_exit;
    key_code = 4'd14; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    tests++; if (unlocked !== 1'b0 || key_ack !== 1'b1 || digit_count !== 4'd0) begin fails++; $display("FAIL star_exit: got %b/%b/%0d expected 0/1/0", unlocked, key_ack, digit_count); end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout_key;
    type_code(16'h1234);
    repeat (16) @(posedge clk);
    #1;
    tests++; if (unlocked !== 1'b1) begin fails++; $display("FAIL pre_timeout: got %b expected 1", unlocked); end
    a0 = ack_cnt;
    key_code = 4'd7; key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    tests++; if (unlocked !== 1'b0 || digit_count !== 4'd0) begin fails++; $display("FAIL timeout_key: got %b/%0d expected 0/0", unlocked, digit_count); end
    repeat (4) @(posedge clk);
    #1;
    tests++; if (ack_cnt - a0 !== 1 || entry_digits !== 16'h0000) begin fails++; $display("FAIL timeout_discard: got %0d/%h expected 1/0000", ack_cnt - a0, entry_digits); end
  endtask

`ifndef PIN_CHANGE_EN
  task automatic test_a_ignored;
    type_code(16'h1234);
    press(4'd10);
    tests++; if (unlocked !== 1'b1 || entry_digits !== 16'h1234) begin fails++; $display("FAIL a_ignored: got %b/%h expected 1/1234", unlocked, entry_digits); end
    test_star_exit();
  endtask
`else
  task automatic test_pin_change;
    type_code(16'h1234);
    press(4'd10);
    tests++; if (unlocked !== 1'b1 || digit_count !== 4'd0) begin fails++; $display("FAIL set_enter: got %b/%0d expected 1/0", unlocked, digit_count); end
    e0 = err_cnt;
    type_code(16'h7777);
    tests++; if (unlocked !== 1'b0 || err_cnt != e0) begin fails++; $display("FAIL set_store: got %b/%0d expected 0/0", unlocked, err_cnt - e0); end
    type_code(16'h1234);
    tests++; if (unlocked !== 1'b0 || err_cnt - e0 !== 1) begin fails++; $display("FAIL old_pin: got %b/%0d expected 0/1", unlocked, err_cnt - e0); end
    type_code(16'h7777);
    tests++; if (unlocked !== 1'b1) begin fails++; $display("FAIL new_pin: got %b expected 1", unlocked); end
    press(4'd10);
    press(4'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    tests++; if ({key_ack, err, unlocked, locked_out} !== 4'b0000 || digit_count !== 4'd0 || entry_digits !== 16'h0000) begin fails++; $display("FAIL set_reset: got %b/%0d/%h expected 0000/0/0000", {key_ack, err, unlocked, locked_out}, digit_count, entry_digits); end
    type_code(16'h1234);
    tests++; if (unlocked !== 1'b1) begin fails++; $display("FAIL pin_restored: got %b expected 1", unlocked); end
    test_star_exit();
  endtask
`endif

  initial begin
    tests = 0; fails = 0;
    ack_cnt = 0; err_cnt = 0; unl_cnt = 0; lk_cnt = 0;
    test_reset();
    test_hold();
    test_unlock();
    test_short();
    test_lockout();
    test_star_exit();
    test_timeout_key();
`ifndef PIN_CHANGE_EN
    test_a_ignored();
`else
    test_pin_change();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
